// File: rtl/mem_arbiter_if.sv
// Bundle between the core (fetch and data ports), the arbiter and the single-port RAM.
interface mem_arbiter_if;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    // Instruction-fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    // Data port
    logic              dm_ren;
    logic              dm_wen;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ack;
    logic [DATA_W-1:0] dm_rdata;

    // RAM command port
    logic              ram_ren;
    logic              ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // PC advance permission
    logic              pc_enable;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, dm_ren, dm_wen, dm_addr, dm_wdata, ram_rdata,
        output if_ack, if_rdata, dm_ack, dm_rdata,
        output ram_ren, ram_wen, ram_addr, ram_wdata, pc_enable
    );

    // Core / RAM side
    modport master (
        output if_req, if_addr, dm_ren, dm_wen, dm_addr, dm_wdata, ram_rdata,
        input  if_ack, if_rdata, dm_ack, dm_rdata,
        input  ram_ren, ram_wen, ram_addr, ram_wdata, pc_enable
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single-port RAM.
// One transaction at a time: IDLE -> GRANT -> WAIT -> ACK, four cycles per access.
module mem_arbiter (
    input  logic         clk,
    input  logic         nRst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_DM = 1'b1;

    state_t state;
    logic   last_grant;   // requester served by the most recent completed access
    logic   req_id;       // requester owning the access in flight
    logic   req_wr;       // access in flight is a write

    logic   dm_req_c;
    logic   pick_dm_c;

    // Data port is pending on either strobe; a tie goes to whoever was not served last
    assign dm_req_c  = bus.dm_ren | bus.dm_wen;
    assign pick_dm_c = dm_req_c & (~bus.if_req | (last_grant == GNT_IF));

    // PC may advance on a data ack, or on a fetch ack that is not waiting on a load/store
    assign bus.pc_enable = bus.dm_ack | (bus.if_ack & ~bus.dm_ren & ~bus.dm_wen);

    // Arbitration FSM with registered RAM command, acks and read data
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state         <= ST_IDLE;
            last_grant    <= GNT_DM;
            req_id        <= GNT_IF;
            req_wr        <= 1'b0;
            bus.if_ack    <= 1'b0;
            bus.dm_ack    <= 1'b0;
            bus.if_rdata  <= '0;
            bus.dm_rdata  <= '0;
            bus.ram_ren   <= 1'b0;
            bus.ram_wen   <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
        end else begin
            bus.if_ack  <= 1'b0;
            bus.dm_ack  <= 1'b0;
            bus.ram_ren <= 1'b0;
            bus.ram_wen <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (bus.if_req | dm_req_c) begin
                        req_id      <= pick_dm_c;
                        // Both data strobes high is treated as a write
                        req_wr      <= pick_dm_c & bus.dm_wen;
                        bus.ram_ren <= ~(pick_dm_c & bus.dm_wen);
                        bus.ram_wen <= pick_dm_c & bus.dm_wen;
                        if (pick_dm_c) begin
                            bus.ram_addr  <= bus.dm_addr;
                            bus.ram_wdata <= bus.dm_wdata;
                        end else begin
                            bus.ram_addr  <= bus.if_addr;
                        end
                        state <= ST_GRANT;
                    end
                end

                ST_GRANT: begin
                    state <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (!req_wr) begin
                        if (req_id == GNT_IF) begin
                            bus.if_rdata <= bus.ram_rdata;
                        end else begin
                            bus.dm_rdata <= bus.ram_rdata;
                        end
                    end
                    bus.if_ack <= (req_id == GNT_IF);
                    bus.dm_ack <= (req_id == GNT_DM);
                    state      <= ST_ACK;
                end

                ST_ACK: begin
                    last_grant <= req_id;
                    state      <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM strobes are exclusive and confined to GRANT; acks are exclusive
    a_ram_excl: assert property (@(posedge clk) disable iff (!nRst)
        !(bus.ram_ren && bus.ram_wen));
    a_ram_grant: assert property (@(posedge clk) disable iff (!nRst)
        (bus.ram_ren || bus.ram_wen) |-> (state == ST_GRANT));
    a_ack_excl: assert property (@(posedge clk) disable iff (!nRst)
        !(bus.if_ack && bus.dm_ack));
endmodule
